// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 4;
  localparam int WORD_W    = BYTE_W * NUM_BYTES;

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables; synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NUM_BYTES-1:0] be,
  input  logic [AW-1:0]        index,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  // Contents are deliberately not reset.
  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-masked write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) mem[index][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed wait-state count.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. Once rsp_valid rises, rsp_rdata and
// rsp_err stay constant until that transfer edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  // FSM state is kept as a named internal signal so checkers can bind to it.
  state_t      state;
  state_t      next_state;

  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic        accept;
  logic        access;
  logic        addr_err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign accept = (state == IDLE) && req_valid;
  assign access = (state == WAIT) && (cnt == 4'd0);

  // DEPTH is a power of two, so "word index >= DEPTH" is any set bit above the index.
  assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:AW+2] != '0);

  // Gating with rst drops the storage update if reset lands on the access edge.
  assign mem_we = access && lat_we && !addr_err && rst;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (lat_be),
    .index (lat_addr[AW+1:2]),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= 4'(WAIT_CYCLES);
      end
      if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_rdata <= (lat_we || addr_err) ? 32'd0 : mem_rdata;
          rsp_err   <= addr_err;
        end
      end
      // Clear on completion so rdata reads 0 whenever no response is held.
      if ((state == RESP) && rsp_ready) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, hand sequences, and a small random model run.
module tb_dmem_responder;
  import dmem_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_valid0;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  // sel chooses which instance the driver tasks talk to
  logic        sel;
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;
  assign cur_req_ready = sel ? req_ready0 : req_ready;
  assign cur_rsp_valid = sel ? rsp_valid0 : rsp_valid;
  assign cur_rsp_err   = sel ? rsp_err0   : rsp_err;
  assign cur_rsp_rdata = sel ? rsp_rdata0 : rsp_rdata;

  // Scoreboard
  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] model [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.rdata = rdata; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic set_valid(input logic v);
    if (sel) req_valid0 = v;
    else     req_valid  = v;
  endtask

  // Driver: one full request/response; hold = cycles to keep rsp_ready low in RESP
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold);
    int n;
    int lat;
    logic [32:0] e;
    lat = sel ? 1 : 3;
    n = 0;
    while (!cur_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", {31'd0, cur_req_ready}, 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    set_valid(1'b1);
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    set_valid(1'b0);
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    chk("req_ready_busy", {31'd0, cur_req_ready}, 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!cur_rsp_valid && n < 40);
    chk("latency", n, lat);
    e = exp_q.pop_front();
    chk("rdata", cur_rsp_rdata, e[31:0]);
    chk("err", {31'd0, cur_rsp_err}, {31'd0, e[32]});
    for (int i = 0; i < hold; i++) begin
      req_we = 1'($urandom); req_addr = $urandom & 32'hFC; req_wdata = $urandom; req_be = 4'hF;
      set_valid(1'b1);
      @(negedge clk);
      chk("hold_valid", {31'd0, cur_rsp_valid}, 32'd1);
      chk("hold_rdata", cur_rsp_rdata, e[31:0]);
      chk("hold_err", {31'd0, cur_rsp_err}, {31'd0, e[32]});
      chk("hold_req_ready", {31'd0, cur_req_ready}, 32'd0);
    end
    set_valid(1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {31'd0, cur_rsp_valid}, 32'd0);
    chk("rdata_idle_zero", cur_rsp_rdata, 32'd0);
    chk("req_ready_back", {31'd0, cur_req_ready}, 32'd1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [31:0] d;
    logic [3:0]  b;
    rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0; sel = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_valid0", {31'd0, rsp_valid0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

    // Vector table: we, addr, wdata, be, expected rdata, expected err
    add_vec(1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        0);
    add_vec(0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 0);
    add_vec(1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        0);
    add_vec(0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 0);
    add_vec(1, 32'h10,  32'h11223344, 4'h0, 32'h0,        0);
    add_vec(0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 0);
    add_vec(1, 32'h00,  32'h01020304, 4'hF, 32'h0,        0);
    add_vec(1, 32'h20,  32'h00000000, 4'hF, 32'h0,        0);
    add_vec(0, 32'h12,  32'h0,        4'hF, 32'h0,        1);
    add_vec(0, 32'h100, 32'h0,        4'hF, 32'h0,        1);
    add_vec(1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0,        1);
    add_vec(1, 32'h11,  32'hFFFFFFFF, 4'hF, 32'h0,        1);
    add_vec(0, 32'h00,  32'h0,        4'hF, 32'h01020304, 0);
    add_vec(0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 0);
    add_vec(0, 32'h20,  32'h0,        4'hF, 32'h00000000, 0);
    add_vec(1, 32'hFC,  32'hCAFEF00D, 4'hF, 32'h0,        0);
    add_vec(0, 32'hFC,  32'h0,        4'hF, 32'hCAFEF00D, 0);
    add_vec(1, 32'h14,  32'h55667788, 4'hF, 32'h0,        0);
    add_vec(1, 32'h14,  32'hAABBCCDD, 4'h6, 32'h0,        0);
    add_vec(0, 32'h14,  32'h0,        4'h9, 32'h55BBCC88, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rdata, vecs[i].err, 0);
    end

    // Response held for 5 cycles with a stray request presented
    do_txn(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 0, 5);
    do_txn(0, 32'h20, 32'h0, 4'hF, 32'h00000000, 0, 0);

    // Reset during the wait phase of a write drops it
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    do_txn(0, 32'h20, 32'h0, 4'hF, 32'h00000000, 0, 0);

    // Random byte-masked traffic on words 16..31 against a bench model
    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      model[k] = d;
      do_txn(1, 32'h40 + 32'(k*4), d, 4'hF, 32'h0, 0, 0);
    end
    for (int k = 0; k < 24; k++) begin
      w = $urandom_range(0, 15);
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        model[w] = merge(model[w], d, b);
        do_txn(1, 32'h40 + 32'(w*4), d, b, 32'h0, 0, 0);
      end else begin
        do_txn(0, 32'h40 + 32'(w*4), d, b, model[w], 0, $urandom_range(0, 2));
      end
    end

    // Zero-wait instance
    sel = 1'b1;
    do_txn(1, 32'h08, 32'h00000077, 4'hF, 32'h0,        0, 0);
    do_txn(0, 32'h08, 32'h0,        4'hF, 32'h00000077, 0, 2);
    do_txn(0, 32'h102, 32'h0,       4'hF, 32'h0,        1, 0);
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64: storage size in 32-bit words (power of 2, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra wait cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator takes the response.
REQ-013 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 IDLE SHALL drive req_ready=1 and rsp_valid=0; WAIT and RESP SHALL drive req_ready=0.
REQ-017 A request SHALL be accepted on the edge where req_valid & req_ready; it SHALL latch we/addr/wdata/be, load wait counter with WAIT_CYCLES, and go to WAIT.
REQ-018 In WAIT, counter != 0 SHALL decrement it; counter == 0 SHALL perform the access on that edge, register rdata/err, and go to RESP.
REQ-019 Latency SHALL be: accept at edge T, rsp_valid first high after edge T+WAIT_CYCLES+1.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1; that edge SHALL return to IDLE.
REQ-021 The responder SHALL allow one outstanding request; back-to-back requests SHALL be spaced by at least one IDLE cycle.
REQ-022 Word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-023 rsp_err SHALL be 1 if req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH; such accesses SHALL NOT modify storage and SHALL return rdata=0.
REQ-024 A write SHALL update only the bytes whose req_be bit is 1; req_be=0000 SHALL be a legal no-op write with rsp_err=0.
REQ-025 A read SHALL return the full word and ignore req_be.
REQ-026 Request inputs outside the accept edge SHALL be ignored.
REQ-027 rsp_rdata SHALL be 0 whenever rsp_valid=0.

Reset
REQ-028 When rst=0 at a rising edge: state SHALL be IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL be 1 from the first cycle after release.
REQ-029 Reset SHALL take priority over every other event on the same edge; an in-flight access whose storage update has not yet happened SHALL be dropped with no write.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state encodings, DEPTH/WAIT_CYCLES defaults and the byte-lane width constant.
REQ-032 Storage and byte-masked write SHALL be one sub-module dmem_array (synchronous write, combinational read) instantiated once.

Verification
REQ-033 Write 0xDEADBEEF to addr 0x10 with be=1111, WAIT_CYCLES=2 -> rsp_valid after edge T+3, err=0; a read of 0x10 returns 0xDEADBEEF.
REQ-034 Write 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF -> a read of 0x10 returns 0xDEADBEAA.
REQ-035 Read 0x12 (misaligned) and read 0x100 with DEPTH=64 (out of range) -> err=1, rdata=0; a write to 0x100 leaves every word unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0 and a new req_valid ignored; rsp_ready=1 -> IDLE the next cycle.
REQ-037 Assert rst=0 in WAIT of a write of 0x12345678 to 0x20 (previously 0x0) -> outputs at reset values, read of 0x20 returns 0x0.
REQ-038 WAIT_CYCLES=0: accept at edge T -> rsp_valid after edge T+1.
